// File: rtl/muldiv_pkg.sv
// Shared state encoding, op constants and helpers for the MULT/DIV sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    WRITE,
    DONE,
    EXC,
    TOUT
  } muldivState_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // The HI/LO selectors follow the latched op only while an operation is in flight.
  function automatic logic selTracksOp(muldivState_t s);
    return (s == LAUNCH) || (s == WAIT) || (s == WRITE) || (s == DONE);
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// WAIT-state watchdog: saturating cycle counter with terminal-count compare.
// Only built when MULDIV_TIMEOUT_EN is defined.
`ifdef MULDIV_TIMEOUT_EN
module muldiv_watchdog #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Terminal count reached during the last allowed WAIT cycle.
  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divisor pair and the HI/LO writeback for Controle.
// Optional WAIT watchdog (TOUT state, timeout_exc) is enabled by defining MULDIV_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for req; op latched when req is accepted
// LAUNCH | start pulse to the selected unit
// WAIT   | waiting for the selected unit's fim
// WRITE  | HI/LO write enables asserted
// DONE   | done pulse to Controle
// EXC    | divide-by-zero exception pulse, no write
// TOUT   | watchdog exception pulse, no write
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic op,
  output logic busy,
  output logic done,
  output logic mult_start,
  output logic div_start,
  input  logic mult_fim,
  input  logic div_fim,
  input  logic div_by_zero,
  output logic hi_sel,
  output logic lo_sel,
  output logic hi_write,
  output logic lo_write,
  output logic div_zero_exc,
  output logic timeout_exc
);

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : gBadCntW
    $error("muldiv_sequencer: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  muldivState_t state;
  muldivState_t stateNext;
  logic         opQ;
  logic         opNext;
  logic         fim;
  logic         timeoutHit;

  logic busyNext;
  logic doneNext;
  logic multStartNext;
  logic divStartNext;
  logic selQ;
  logic selNext;
  logic writeQ;
  logic writeNext;
  logic divZeroExcNext;

  // Only the unit that was launched can complete the operation.
  assign fim = (opQ == OP_DIV) ? div_fim : mult_fim;

`ifdef MULDIV_TIMEOUT_EN
  logic wdClear;
  logic wdCount;
  logic timeoutExcQ;
  logic timeoutExcNext;

  assign wdClear = (state == LAUNCH);
  assign wdCount = (state == WAIT) && !fim;

  muldiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) uWatchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wdClear),
    .count  (wdCount),
    .expired(timeoutHit)
  );
`else
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    opNext    = opQ;

    case (state)
      IDLE: begin
        if (req) begin
          opNext    = op;
          stateNext = LAUNCH;
        end
      end
      LAUNCH: stateNext = WAIT;
      WAIT: begin
        if (fim) begin
          stateNext = ((opQ == OP_DIV) && div_by_zero) ? EXC : WRITE;
        end else if (timeoutHit) begin
          stateNext = TOUT;
        end
      end
      WRITE:   stateNext = DONE;
      default: stateNext = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they never glitch.
    busyNext       = (stateNext != IDLE);
    multStartNext  = (stateNext == LAUNCH) && (opNext == OP_MULT);
    divStartNext   = (stateNext == LAUNCH) && (opNext == OP_DIV);
    writeNext      = (stateNext == WRITE);
    doneNext       = (stateNext == DONE);
    divZeroExcNext = (stateNext == EXC);
    selNext        = selTracksOp(stateNext) ? opNext : selQ;
`ifdef MULDIV_TIMEOUT_EN
    timeoutExcNext = (stateNext == TOUT);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      opQ          <= OP_MULT;
      busy         <= 1'b0;
      done         <= 1'b0;
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      selQ         <= 1'b0;
      writeQ       <= 1'b0;
      div_zero_exc <= 1'b0;
    end else begin
      state        <= stateNext;
      opQ          <= opNext;
      busy         <= busyNext;
      done         <= doneNext;
      mult_start   <= multStartNext;
      div_start    <= divStartNext;
      selQ         <= selNext;
      writeQ       <= writeNext;
      div_zero_exc <= divZeroExcNext;
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeoutExcQ <= 1'b0;
    end else begin
      timeoutExcQ <= timeoutExcNext;
    end
  end

  assign timeout_exc = timeoutExcQ;
`else
  assign timeout_exc = 1'b0;
`endif

  assign hi_sel   = selQ;
  assign lo_sel   = selQ;
  assign hi_write = writeQ;
  assign lo_write = writeQ;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed scoreboard bench for muldiv_sequencer; the timeout scenario runs when MULDIV_TIMEOUT_EN is defined.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clock;
  logic reset;
  logic req;
  logic op;
  logic busy;
  logic done;
  logic mult_start;
  logic div_start;
  logic mult_fim;
  logic div_fim;
  logic div_by_zero;
  logic hi_sel;
  logic lo_sel;
  logic hi_write;
  logic lo_write;
  logic div_zero_exc;
  logic timeout_exc;

  muldiv_sequencer #(
    .TIMEOUT_CYCLES(40),
    .CNT_W         (6)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .op          (op),
    .busy        (busy),
    .done        (done),
    .mult_start  (mult_start),
    .div_start   (div_start),
    .mult_fim    (mult_fim),
    .div_fim     (div_fim),
    .div_by_zero (div_by_zero),
    .hi_sel      (hi_sel),
    .lo_sel      (lo_sel),
    .hi_write    (hi_write),
    .lo_write    (lo_write),
    .div_zero_exc(div_zero_exc),
    .timeout_exc (timeout_exc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Result event encoding: {timeout_exc, div_zero_exc, lo_write, hi_write}
  localparam logic [3:0] K_WRITE = 4'b0011;
  localparam logic [3:0] K_EXC   = 4'b0100;
`ifdef MULDIV_TIMEOUT_EN
  localparam logic [3:0] K_TOUT  = 4'b1000;
`endif

  typedef struct {
    logic [3:0] kind;
    logic       sel;
    int         at;
  } expT;

  expT expQ[$];

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;
  int multStarts  = 0;
  int divStarts   = 0;
  int doneCount   = 0;
  int writeCount  = 0;
  int lastDoneCyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    assert (obs === expv) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [9:0] allOuts();
    return {busy, done, mult_start, div_start, hi_sel, lo_sel,
            hi_write, lo_write, div_zero_exc, timeout_exc};
  endfunction

  // Advance one cycle, sample outputs #1 after the edge and retire scoreboard entries.
  task automatic tick();
    expT        e;
    logic [3:0] evt;
    @(posedge clock);
    #1;
    cyc++;
    if (mult_start) multStarts++;
    if (div_start) divStarts++;
    if (done) begin
      doneCount++;
      lastDoneCyc = cyc;
    end
    if (hi_write || lo_write) writeCount++;
    evt = {timeout_exc, div_zero_exc, lo_write, hi_write};
    if (evt != 4'b0000) begin
      if (expQ.size() == 0) begin
        chk("unexpected_event", {28'd0, evt}, 32'd0);
      end else begin
        e = expQ.pop_front();
        chk("event_kind", {28'd0, evt}, {28'd0, e.kind});
        chk("event_cycle", cyc, e.at);
        if (e.kind == K_WRITE) chk("event_sel", {30'd0, hi_sel, lo_sel}, {30'd0, e.sel, e.sel});
      end
    end
  endtask

  // One operation: req at cycle 0, selected fim at cycle fimAt.
  // reqHold: cycles req stays high; strayAt/reqPulseAt: cycle of a stray other-unit fim / req pulse (0 = none).
  task automatic doOp(input string tag, input logic opv, input int fimAt, input logic dbz,
                      input int reqHold, input int strayAt, input int reqPulseAt, input bit fimInLaunch);
    int   t0;
    int   ms0;
    int   ds0;
    int   dn0;
    int   wr0;
    logic excp;
    expT  e;
    t0   = cyc;
    ms0  = multStarts;
    ds0  = divStarts;
    dn0  = doneCount;
    wr0  = writeCount;
    excp = opv && dbz;
    req  = 1'b1;
    op   = opv;
    e.kind = excp ? K_EXC : K_WRITE;
    e.sel  = opv;
    e.at   = t0 + fimAt + 1;
    expQ.push_back(e);

    tick();
    chk({tag, "_start"}, {29'd0, mult_start, div_start, busy}, {29'd0, ~opv, opv, 1'b1});
    req = (reqHold > 1);
    if (fimInLaunch) begin
      if (opv) div_fim = 1'b1;
      else mult_fim = 1'b1;
    end

    while (cyc < t0 + fimAt) begin
      tick();
      mult_fim    = 1'b0;
      div_fim     = 1'b0;
      div_by_zero = 1'b0;
      req = ((cyc - t0) < reqHold) || ((cyc - t0) == reqPulseAt);
      if ((cyc - t0) == strayAt) begin
        if (opv) begin
          mult_fim = 1'b1;
        end else begin
          div_fim     = 1'b1;
          div_by_zero = 1'b1;
        end
      end
    end

    chk({tag, "_wait_sel"}, {29'd0, hi_sel, lo_sel, busy}, {29'd0, opv, opv, 1'b1});
    req         = 1'b0;
    mult_fim    = ~opv;
    div_fim     = opv;
    div_by_zero = dbz;
    tick();
    mult_fim    = 1'b0;
    div_fim     = 1'b0;
    div_by_zero = 1'b0;
    tick();
    tick();

    chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pending"}, expQ.size(), 32'd0);
    chk({tag, "_mult_starts"}, multStarts - ms0, {31'd0, ~opv});
    chk({tag, "_div_starts"}, divStarts - ds0, {31'd0, opv});
    chk({tag, "_writes"}, writeCount - wr0, {31'd0, ~excp});
    chk({tag, "_dones"}, doneCount - dn0, {31'd0, ~excp});
    if (!excp) chk({tag, "_done_cycle"}, lastDoneCyc, t0 + fimAt + 2);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit: observed no finish expected finish before limit");
    $fatal(1, "time limit");
  end

  initial begin
    int  t0;
    int  wr0;
    int  dn0;
    int  st0;
    expT e;

    reset       = 1'b0;
    req         = 1'b0;
    op          = 1'b0;
    mult_fim    = 1'b0;
    div_fim     = 1'b0;
    div_by_zero = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {22'd0, allOuts()}, 32'd0);
    #2 reset = 1'b1;
    tick();
    chk("idle_after_reset", {22'd0, allOuts()}, 32'd0);

    doOp("mult",        OP_MULT, 34, 1'b0, 1, 0,  0,  1'b0);
    doOp("div_7_2",     OP_DIV,  20, 1'b0, 1, 0,  0,  1'b0);
    doOp("div_zero",    OP_DIV,  10, 1'b1, 1, 0,  0,  1'b0);
    doOp("mult_stray",  OP_MULT, 20, 1'b0, 1, 8,  12, 1'b0);
    doOp("b2b_held",    OP_DIV,  15, 1'b0, 3, 0,  0,  1'b0);
    doOp("launch_fim",  OP_MULT, 6,  1'b0, 1, 0,  0,  1'b1);
    doOp("div_stray",   OP_DIV,  9,  1'b0, 1, 4,  0,  1'b1);
    doOp("fim_at_tc",   OP_MULT, 41, 1'b0, 1, 0,  0,  1'b0);

`ifdef MULDIV_TIMEOUT_EN
    // No fim: 40 WAIT cycles (c2..c41), TOUT at c42, IDLE at c43.
    t0  = cyc;
    wr0 = writeCount;
    dn0 = doneCount;
    req = 1'b1;
    op  = OP_MULT;
    e.kind = K_TOUT;
    e.sel  = OP_MULT;
    e.at   = t0 + 42;
    expQ.push_back(e);
    tick();
    req = 1'b0;
    repeat (41) tick();
    chk("tout_pulse", {31'd0, timeout_exc}, 32'd1);
    tick();
    chk("tout_idle", {30'd0, busy, timeout_exc}, 32'd0);
    chk("tout_pending", expQ.size(), 32'd0);
    chk("tout_no_write", writeCount - wr0, 32'd0);
    chk("tout_no_done", doneCount - dn0, 32'd0);
`else
    doOp("long_wait",   OP_DIV,  60, 1'b0, 1, 0,  0,  1'b0);
`endif

    // Reset during WAIT of a DIV: outputs clear at once and nothing is written afterwards.
    wr0 = writeCount;
    dn0 = doneCount;
    req = 1'b1;
    op  = OP_DIV;
    tick();
    req = 1'b0;
    repeat (4) tick();
    chk("rst_pre_state", {29'd0, busy, hi_sel, lo_sel}, 32'd7);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_outputs", {22'd0, allOuts()}, 32'd0);
    #2 reset = 1'b1;
    st0 = multStarts + divStarts;
    tick();
    div_fim = 1'b1;
    tick();
    div_fim = 1'b0;
    tick();
    tick();
    chk("rst_idle_after", {22'd0, allOuts()}, 32'd0);
    chk("rst_no_write", writeCount - wr0, 32'd0);
    chk("rst_no_done", doneCount - dn0, 32'd0);
    chk("rst_no_start", multStarts + divStarts - st0, 32'd0);

    doOp("after_rst",   OP_MULT, 5,  1'b0, 1, 0,  0,  1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
